i2s_serializer: RTL and testbench

//   Downstream stage of the tone engine: accepts one stereo 16-bit sample pair per

---
 rtl/i2s_serializer.sv | 122 ++++++++++++
 tb/tb_i2s_serializer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_serializer.sv
// Philips I2S transmitter: divides clk down to BCLK, shifts out one stereo
// frame per 2*SAMPLE_W bit clocks, with a one-deep sample buffer and underrun mute.
module i2s_serializer #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] sample_l_in,
  input  logic [SAMPLE_W-1:0] sample_r_in,
  input  logic                sample_valid_in,
  output logic                sample_ready_out,
  output logic                i2s_bclk_out,
  output logic                i2s_ws_out,
  output logic                i2s_d_out,
  output logic                underrun_out
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned FRAME  = 2 * SAMPLE_W;
  localparam int unsigned SLOT_W = $clog2(FRAME);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME - 1);
  localparam logic [SLOT_W-1:0] WS_FIRST  = SLOT_W'(SAMPLE_W - 1);
  localparam logic [SLOT_W-1:0] WS_LAST   = SLOT_W'(FRAME - 2);

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_t;

  hold_state_t         hold_state, hold_nxt;
  logic [SAMPLE_W-1:0] hold_l, hold_r;
  logic [DIV_W-1:0]    div_cnt;
  logic [SLOT_W-1:0]   slot_cnt, slot_nxt;
  logic [FRAME-1:0]    shift_reg, load_data;
  logic                bclk, ws, sd, underrun;
  logic                tick, fall_evt, frame_load, capture, mute, ws_nxt;

  always_comb begin
    tick       = (div_cnt == DIV_LAST);
    fall_evt   = tick & bclk;
    slot_nxt   = (slot_cnt == SLOT_LAST) ? '0 : slot_cnt + 1'b1;
    frame_load = fall_evt && (slot_nxt == '0);
    ws_nxt     = (slot_nxt >= WS_FIRST) && (slot_nxt <= WS_LAST);
  end

  // Load priority: buffered pair, then a pair offered in the load clock itself
  // (bypass, handshake completes without touching the buffer), else silence.
  always_comb begin
    hold_nxt  = hold_state;
    capture   = 1'b0;
    mute      = 1'b0;
    load_data = '0;
    if (hold_state == HOLD_FULL) begin
      load_data = {hold_l, hold_r};
      if (frame_load) hold_nxt = HOLD_EMPTY;
    end else if (sample_valid_in) begin
      load_data = {sample_l_in, sample_r_in};
      if (!frame_load) begin
        capture  = 1'b1;
        hold_nxt = HOLD_FULL;
      end
    end else begin
      mute = frame_load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_state <= HOLD_EMPTY;
      hold_l     <= '0;
      hold_r     <= '0;
    end else begin
      hold_state <= hold_nxt;
      if (capture) begin
        hold_l <= sample_l_in;
        hold_r <= sample_r_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      bclk      <= 1'b0;
      slot_cnt  <= SLOT_LAST;
      shift_reg <= '0;
      ws        <= 1'b0;
      sd        <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (tick) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (fall_evt) begin
        slot_cnt <= slot_nxt;
        ws       <= ws_nxt;
        if (frame_load) begin
          shift_reg <= load_data;
          sd        <= load_data[FRAME-1];
          underrun  <= mute;
        end else begin
          shift_reg <= {shift_reg[FRAME-2:0], 1'b0};
          sd        <= shift_reg[FRAME-2];
        end
      end
    end
  end

  assign sample_ready_out = (hold_state == HOLD_EMPTY);
  assign i2s_bclk_out     = bclk;
  assign i2s_ws_out       = ws;
  assign i2s_d_out        = sd;
  assign underrun_out     = underrun;

endmodule

// File: tb/tb_i2s_serializer.sv
// Scoreboard bench for i2s_serializer: CLK_DIV=2 and CLK_DIV=1 instances, expected
// frames queued by stimulus and checked by an independent I2S receiver model.
module tb_i2s_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_n, valid, ready, bclk, ws, sd, und;
  logic [15:0] sl [2];
  logic [15:0] sr [2];
  int unsigned cyc [2];
  int          n_vec = 0;
  int          n_err = 0;
  bit [1:0]    stop_mon = '0;
  bit [1:0]    mon_done = '0;
  logic [32:0] exp_q0 [$];
  logic [32:0] exp_q1 [$];

  i2s_serializer #(.CLK_DIV(2), .SAMPLE_W(16)) u_div2 (
    .clk(clk), .rst_n(rst_n[0]), .sample_l_in(sl[0]), .sample_r_in(sr[0]),
    .sample_valid_in(valid[0]), .sample_ready_out(ready[0]), .i2s_bclk_out(bclk[0]),
    .i2s_ws_out(ws[0]), .i2s_d_out(sd[0]), .underrun_out(und[0]));

  i2s_serializer #(.CLK_DIV(1), .SAMPLE_W(16)) u_div1 (
    .clk(clk), .rst_n(rst_n[1]), .sample_l_in(sl[1]), .sample_r_in(sr[1]),
    .sample_valid_in(valid[1]), .sample_ready_out(ready[1]), .i2s_bclk_out(bclk[1]),
    .i2s_ws_out(ws[1]), .i2s_d_out(sd[1]), .underrun_out(und[1]));

  // Clocks since reset release; the first rising edge after release is cycle 1.
  always @(posedge clk) begin
    cyc[0] <= rst_n[0] ? cyc[0] + 1 : 0;
    cyc[1] <= rst_n[1] ? cyc[1] + 1 : 0;
  end

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic push(input int k, input logic [15:0] l, input logic [15:0] r, input logic u);
    if (k == 0) exp_q0.push_back({u, l, r});
    else        exp_q1.push_back({u, l, r});
  endtask

  task automatic wait_cyc(input int k, input int unsigned n);
    int unsigned guard = 0;
    while (cyc[k] != n && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc[k] != n) timeout("wait_cyc");
  endtask

  // Entered at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input int k, input logic [15:0] l, input logic [15:0] r);
    int unsigned guard = 0;
    sl[k]    = l;
    sr[k]    = r;
    valid[k] = 1'b1;
    while (!ready[k] && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (!ready[k]) timeout("send_ready");
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input int k);
    check("rst_bclk", bclk[k], 1'b0);
    check("rst_ws", ws[k], 1'b0);
    check("rst_sd", sd[k], 1'b0);
    check("rst_underrun", und[k], 1'b0);
    check("rst_ready", ready[k], 1'b1);
  endtask

  // Receiver model: tracks slots from BCLK falls, samples SD/WS on BCLK rises.
  task automatic monitor(input int k);
    logic        prev_b = 1'b0;
    int          slot = 31;
    bit          have = 1'b0;
    bit          done = 1'b0;
    logic [32:0] cur = '0;
    logic [31:0] got = '0;
    int          ws_bad = 0;
    int          und_cnt = 0;
    bit          q_empty;
    while (!done) begin
      @(negedge clk);
      if (!rst_n[k]) begin
        prev_b = 1'b0;
        slot   = 31;
        have   = 1'b0;
        continue;
      end
      if (have && und[k]) und_cnt++;
      if (prev_b && !bclk[k]) begin
        slot = (slot + 1) % 32;
        if (slot == 0) begin
          q_empty = (k == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
          if (q_empty) begin
            have = 1'b0;
            if (stop_mon[k]) done = 1'b1;
            else begin
              n_vec++;
              n_err++;
              $display("FAIL unexpected_frame: dut %0d started a frame with none queued", k);
            end
          end else begin
            cur     = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            have    = 1'b1;
            got     = '0;
            ws_bad  = 0;
            und_cnt = und[k] ? 1 : 0;
          end
        end
      end else if (!prev_b && bclk[k] && have) begin
        if (ws[k] !== ((slot >= 15) && (slot <= 30))) ws_bad++;
        got[31 - slot] = sd[k];
        if (slot == 31) begin
          check("frame_data", {1'b0, got}, {1'b0, cur[31:0]});
          check("frame_underrun", und_cnt, {32'd0, cur[32]});
          check("frame_ws", ws_bad, '0);
          have = 1'b0;
        end
      end
      prev_b = bclk[k];
    end
    mon_done[k] = 1'b1;
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = '0;
    valid = '0;
    sl[0] = '0; sr[0] = '0; sl[1] = '0; sr[1] = '0;
    fork
      begin : stim_div2
        push(0, 16'hA5F0, 16'h0F5A, 1'b0);
        push(0, 16'h8001, 16'h7FFE, 1'b0);
        push(0, 16'hFFFF, 16'h0000, 1'b0);
        push(0, 16'h1234, 16'hFEDC, 1'b0);
        push(0, 16'h0001, 16'h8000, 1'b0);
        repeat (3) push(0, 16'h0000, 16'h0000, 1'b1);
        push(0, 16'hC3C3, 16'h3C3C, 1'b0);
        push(0, 16'h0000, 16'h0000, 1'b1);
        repeat (3) @(negedge clk);
        check_reset_outputs(0);
        // Pair offered before the first fall event is played in frame 0.
        sl[0] = 16'hA5F0; sr[0] = 16'h0F5A; valid[0] = 1'b1;
        #2 rst_n[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        send(0, 16'h8001, 16'h7FFE);
        send(0, 16'hFFFF, 16'h0000);
        send(0, 16'h1234, 16'hFEDC);
        send(0, 16'h0001, 16'h8000);
        valid[0] = 1'b0;
        // Frames 5..7 play muted; frame 8 loads at cycle 1028 with the buffer empty.
        wait_cyc(0, 1027);
        check("bypass_ready", ready[0], 1'b1);
        sl[0] = 16'hC3C3; sr[0] = 16'h3C3C; valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid[0] = 1'b0;
        // Frame 9 is muted; fill the buffer mid-frame, then reset in slot 20.
        wait_cyc(0, 1200);
        send(0, 16'hDEAD, 16'hBEEF);
        valid[0] = 1'b0;
        wait_cyc(0, 1238);
        check("pending_ready", ready[0], 1'b0);
        check("pre_reset_bclk", bclk[0], 1'b1);
        #2 rst_n[0] = 1'b0;
        #1 check_reset_outputs(0);
        push(0, 16'h5A5A, 16'hA5A5, 1'b0);
        push(0, 16'h0000, 16'h0000, 1'b1);
        stop_mon[0] = 1'b1;
        sl[0] = 16'h5A5A; sr[0] = 16'hA5A5; valid[0] = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
      end
      begin : stim_div1
        push(1, 16'hA5F0, 16'h0F5A, 1'b0);
        push(1, 16'h0000, 16'h0000, 1'b1);
        stop_mon[1] = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs(1);
        sl[1] = 16'hA5F0; sr[1] = 16'h0F5A; valid[1] = 1'b1;
        #2 rst_n[1] = 1'b1;
        @(negedge clk);
        valid[1] = 1'b0;
      end
    join
    for (int i = 0; i < 3000 && mon_done != 2'b11; i++) @(negedge clk);
    if (mon_done != 2'b11) timeout("monitor_done");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
